// File: rtl/lpc_dp_buffer_if.sv
// Dual-port bus bundle for lpc_dp_buffer: port A (s1) and port B (s2).
interface lpc_dp_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  localparam int BE_W = DATA_W / 8;

  // port A (s1)
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  // port B (s2)
  logic [ADDR_W-1:0] address2;
  logic [BE_W-1:0]   byteenable2;
  logic              chipselect2;
  logic              read2;
  logic              write2;
  logic [DATA_W-1:0] writedata2;
  logic [DATA_W-1:0] readdata2;
  logic              readdatavalid2;
  logic              waitrequest2;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    output address2, byteenable2, chipselect2, read2, write2, writedata2,
    input  readdata, readdatavalid, waitrequest,
    input  readdata2, readdatavalid2, waitrequest2
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    input  address2, byteenable2, chipselect2, read2, write2, writedata2,
    output readdata, readdatavalid, waitrequest,
    output readdata2, readdatavalid2, waitrequest2
  );
endinterface

// File: rtl/lpc_dp_buffer.sv
// Dual-port byte-enabled word buffer with pipelined reads and an optional
// post-reset clear sweep. Port A wins per-byte on same-address write collisions;
// reads see the merged post-write word of the same cycle.
module lpc_dp_buffer #(
  parameter int              DATA_W         = 16,
  parameter int              ADDR_W         = 11,
  parameter int              RD_LATENCY     = 1,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
)(
  input  logic            clk,
  input  logic            reset,
  lpc_dp_buffer_if.slave  bus,
  output logic            init_done
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W  = DATA_W / 8;
  localparam int NP    = 2;   // index 0 = port A, 1 = port B

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              w_waitreq;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [NP-1:0][ADDR_W-1:0] w_addr;
  logic [NP-1:0][BE_W-1:0]   w_be;
  logic [NP-1:0][DATA_W-1:0] w_wdat;
  logic [NP-1:0]             w_wr, w_rd;
  logic [NP-1:0][DATA_W-1:0] w_rword;

  logic [NP-1:0][RD_LATENCY:1]             r_vld_pipe;
  logic [NP-1:0][RD_LATENCY:1][DATA_W-1:0] r_dat_pipe;

  assign w_addr = {bus.address2,    bus.address};
  assign w_be   = {bus.byteenable2, bus.byteenable};
  assign w_wdat = {bus.writedata2,  bus.writedata};

  // read+write together counts as a write only; nothing is accepted in CLEAR
  assign w_wr[0] = bus.chipselect  & bus.write  & ~w_waitreq;
  assign w_wr[1] = bus.chipselect2 & bus.write2 & ~w_waitreq;
  assign w_rd[0] = bus.chipselect  & bus.read  & ~bus.write  & ~w_waitreq;
  assign w_rd[1] = bus.chipselect2 & bus.read2 & ~bus.write2 & ~w_waitreq;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: leave CLEAR after the last address has been written
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CLEAR && r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = S_RUN;
  end

  // FSM outputs
  always_comb begin
    w_waitreq = (r_state == S_CLEAR);
    init_done = ~w_waitreq;
  end

  // clear sweep address counter; wraps to 0 as the sweep finishes
  always_ff @(posedge clk) begin
    if (reset)                   r_clr_cnt <= '0;
    else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  // memory update: port B applied first so port A's later assignment wins each byte
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR) r_mem[r_clr_cnt] <= CLEAR_VALUE;
      for (int p = NP - 1; p >= 0; p--) begin
        if (w_wr[p]) begin
          for (int b = 0; b < BE_W; b++) begin
            if (w_be[p][b]) r_mem[w_addr[p]][8*b +: 8] <= w_wdat[p][8*b +: 8];
          end
        end
      end
    end
  end

  // read word with this cycle's writes merged in (same B-then-A byte priority)
  always_comb begin
    w_rword = '0;
    for (int p = 0; p < NP; p++) begin
      w_rword[p] = r_mem[w_addr[p]];
      for (int q = NP - 1; q >= 0; q--) begin
        if (w_wr[q] && w_addr[q] == w_addr[p]) begin
          for (int b = 0; b < BE_W; b++) begin
            if (w_be[q][b]) w_rword[p][8*b +: 8] = w_wdat[q][8*b +: 8];
          end
        end
      end
    end
  end

  // read pipelines; data stages load only on valid so the last stage holds readdata
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        r_vld_pipe[p][1] <= w_rd[p];
        if (w_rd[p]) r_dat_pipe[p][1] <= w_rword[p];
        for (int s = 2; s <= RD_LATENCY; s++) begin
          r_vld_pipe[p][s] <= r_vld_pipe[p][s-1];
          if (r_vld_pipe[p][s-1]) r_dat_pipe[p][s] <= r_dat_pipe[p][s-1];
        end
      end
    end
  end

  assign bus.readdata       = r_dat_pipe[0][RD_LATENCY];
  assign bus.readdata2      = r_dat_pipe[1][RD_LATENCY];
  assign bus.readdatavalid  = r_vld_pipe[0][RD_LATENCY];
  assign bus.readdatavalid2 = r_vld_pipe[1][RD_LATENCY];
  assign bus.waitrequest    = w_waitreq;
  assign bus.waitrequest2   = w_waitreq;

endmodule
